// File: rtl/qmem_ram_bridge.sv
// Bridges a 32-bit QMEM slave port onto a 16-bit synchronous RAM.
// Each word access is split into a big-endian high/low halfword phase.
module qmem_ram_bridge #(
    parameter int QAW = 22,
    parameter int WS  = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           qs_cs,
    input  logic           qs_we,
    input  logic [QAW-1:0] qs_adr,
    input  logic [3:0]     qs_sel,
    input  logic [31:0]    qs_dat_w,
    output logic [31:0]    qs_dat_r,
    output logic           qs_ack,
    output logic           qs_err,
    output logic [QAW-2:0] mem_adr,
    output logic           mem_cs,
    output logic           mem_we,
    output logic [1:0]     mem_be,
    output logic [15:0]    mem_dat_w,
    input  logic [15:0]    mem_dat_r,
    output logic           busy
);

    typedef enum logic [1:0] {IDLE, HI, LO, ACK} state_t;

    localparam logic [3:0] WS_L = 4'(WS);

    state_t         state, state_nxt;
    logic [QAW-3:0] adr_q;
    logic           we_q;
    logic [3:0]     sel_q;
    logic [31:0]    dat_q;
    logic           err_q;
    logic [3:0]     wcnt;
    logic           phase_end;
    logic           accept;
    logic           unused_adr_lsb;

    // Word-aligned: the byte offset within the word is carried by qs_sel.
    assign unused_adr_lsb = ^qs_adr[1:0];

    assign phase_end = (wcnt == 4'd0);
    assign accept    = (state == IDLE) && qs_cs;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (qs_cs) begin
                if (|qs_sel[3:2])      state_nxt = HI;
                else if (|qs_sel[1:0]) state_nxt = LO;
                else                   state_nxt = ACK;
            end
            HI:  if (phase_end) state_nxt = (|sel_q[1:0]) ? LO : ACK;
            LO:  if (phase_end) state_nxt = ACK;
            ACK: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            adr_q    <= '0;
            we_q     <= 1'b0;
            sel_q    <= 4'd0;
            dat_q    <= 32'd0;
            err_q    <= 1'b0;
            wcnt     <= 4'd0;
            qs_dat_r <= 32'd0;
        end else begin
            if (accept) begin
                adr_q <= qs_adr[QAW-1:2];
                we_q  <= qs_we;
                sel_q <= qs_sel;
                dat_q <= qs_dat_w;
                err_q <= (qs_sel == 4'd0);
                // Reads start from zero so a skipped half returns 0; writes keep old data.
                if (!qs_we) qs_dat_r <= 32'd0;
            end
            if ((state_nxt != state) && (state_nxt == HI || state_nxt == LO))
                wcnt <= WS_L;
            else if (!phase_end)
                wcnt <= wcnt - 4'd1;
            if (state == HI && phase_end && !we_q) qs_dat_r[31:16] <= mem_dat_r;
            if (state == LO && phase_end && !we_q) qs_dat_r[15:0]  <= mem_dat_r;
        end
    end

    always_comb begin
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 2'b00;
        mem_adr   = '0;
        mem_dat_w = 16'd0;
        qs_ack    = (state == ACK);
        qs_err    = (state == ACK) && err_q;
        busy      = (state != IDLE);
        case (state)
            HI: begin
                mem_cs    = 1'b1;
                mem_we    = we_q;
                mem_adr   = {adr_q, 1'b0};
                mem_be    = sel_q[3:2];
                mem_dat_w = dat_q[31:16];
            end
            LO: begin
                mem_cs    = 1'b1;
                mem_we    = we_q;
                mem_adr   = {adr_q, 1'b1};
                mem_be    = sel_q[1:0];
                mem_dat_w = dat_q[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_qmem_ram_bridge.sv
// Bench for qmem_ram_bridge: one WS=1 instance for most scenarios, one WS=0
// instance for back-to-back reads, each with its own halfword RAM model.
module tb_qmem_ram_bridge;
    localparam int QAW = 22;

    typedef struct {
        logic [31:0] dat;
        logic        err;
        logic        chk;
    } exp_t;

    logic clk = 1'b0;
    logic rst, mem_init;
    logic cs1, cs0, qs_we;
    logic [QAW-1:0] qs_adr;
    logic [3:0]     qs_sel;
    logic [31:0]    qs_dat_w;

    logic [31:0] dr1, dr0;
    logic ack1, ack0, err1, err0, mcs1, mcs0, mwe1, mwe0, busy1, busy0;
    logic [QAW-2:0] madr1, madr0;
    logic [1:0] mbe1, mbe0;
    logic [15:0] mdw1, mdw0, mdr1, mdr0;

    logic [15:0] mem1 [0:255];
    logic [15:0] mem0 [0:255];

    int total = 0;
    int bad = 0;
    exp_t q1[$];
    exp_t q0[$];
    logic [31:0] last_rd1;
    logic [QAW-2:0] rec_adr[$];
    logic [1:0]     rec_be[$];
    logic [15:0]    rec_dw[$];
    logic           rec_we[$];

    always #5 clk = ~clk;

    qmem_ram_bridge #(.QAW(QAW), .WS(1)) dut1 (
        .clk(clk), .rst(rst), .qs_cs(cs1), .qs_we(qs_we), .qs_adr(qs_adr),
        .qs_sel(qs_sel), .qs_dat_w(qs_dat_w), .qs_dat_r(dr1), .qs_ack(ack1),
        .qs_err(err1), .mem_adr(madr1), .mem_cs(mcs1), .mem_we(mwe1),
        .mem_be(mbe1), .mem_dat_w(mdw1), .mem_dat_r(mdr1), .busy(busy1)
    );

    qmem_ram_bridge #(.QAW(QAW), .WS(0)) dut0 (
        .clk(clk), .rst(rst), .qs_cs(cs0), .qs_we(qs_we), .qs_adr(qs_adr),
        .qs_sel(qs_sel), .qs_dat_w(qs_dat_w), .qs_dat_r(dr0), .qs_ack(ack0),
        .qs_err(err0), .mem_adr(madr0), .mem_cs(mcs0), .mem_we(mwe0),
        .mem_be(mbe0), .mem_dat_w(mdw0), .mem_dat_r(mdr0), .busy(busy0)
    );

    function automatic logic [15:0] init_val(input int i);
        case (i)
            8:  return 16'h1234;
            9:  return 16'hABCD;
            10: return 16'h5678;
            11: return 16'h9ABC;
            default: return 16'h0000;
        endcase
    endfunction

    assign mdr1 = mem1[madr1[7:0]];
    assign mdr0 = mem0[madr0[7:0]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) begin
                mem1[i] <= init_val(i);
                mem0[i] <= init_val(i);
            end
        end else begin
            if (mcs1 && mwe1) begin
                if (mbe1[1]) mem1[madr1[7:0]][15:8] <= mdw1[15:8];
                if (mbe1[0]) mem1[madr1[7:0]][7:0]  <= mdw1[7:0];
            end
            if (mcs0 && mwe0) begin
                if (mbe0[1]) mem0[madr0[7:0]][15:8] <= mdw0[15:8];
                if (mbe0[0]) mem0[madr0[7:0]][7:0]  <= mdw0[7:0];
            end
        end
    end

    // Scoreboards: every ack pops one expectation; an ack with nothing pending is a failure.
    always @(negedge clk) begin
        exp_t e;
        if (ack1 === 1'b1) begin
            total++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL ack1_unexpected: got ack, required none");
            end else begin
                e = q1.pop_front();
                if (e.err !== err1) begin
                    bad++;
                    $display("FAIL ack1_err: got %b required %b", err1, e.err);
                end
                if (e.chk) begin
                    total++;
                    if (dr1 !== e.dat) begin
                        bad++;
                        $display("FAIL ack1_data: got %h required %h", dr1, e.dat);
                    end
                end
            end
        end
        if (ack0 === 1'b1) begin
            total++;
            if (q0.size() == 0) begin
                bad++;
                $display("FAIL ack0_unexpected: got ack, required none");
            end else begin
                e = q0.pop_front();
                if (dr0 !== e.dat || err0 !== e.err) begin
                    bad++;
                    $display("FAIL ack0_data: got %h/%b required %h/%b", dr0, err0, e.dat, e.err);
                end
            end
        end
    end

    // Issue one request on dut1, hold it until ack, record memory-side cycles.
    task automatic req1(input logic [QAW-1:0] a, input logic we, input logic [3:0] sel,
                        input logic [31:0] d, input logic chg, output int lat);
        rec_adr.delete(); rec_be.delete(); rec_dw.delete(); rec_we.delete();
        @(posedge clk); #1;
        qs_adr = a; qs_we = we; qs_sel = sel; qs_dat_w = d; cs1 = 1'b1;
        lat = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (mcs1) begin
                rec_adr.push_back(madr1); rec_be.push_back(mbe1);
                rec_dw.push_back(mdw1);   rec_we.push_back(mwe1);
            end
            if (ack1) begin
                lat = n;
                break;
            end
            @(posedge clk);
            if (chg && n == 0) begin
                #1;
                qs_adr = 22'h000040; qs_we = 1'b1; qs_sel = 4'h0; qs_dat_w = 32'hFFFFFFFF;
            end
        end
        @(posedge clk); #1;
        cs1 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_init = 1'b1;
        cs1 = 1'b0; cs0 = 1'b0; qs_we = 1'b0; qs_adr = '0; qs_sel = 4'h0; qs_dat_w = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({ack1, err1, mcs1, mwe1, busy1, busy0} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b required 000000", {ack1, err1, mcs1, mwe1, busy1, busy0});
        end
        total++;
        if (dr1 !== 32'd0 || madr1 !== '0 || mbe1 !== 2'b0 || mdw1 !== 16'd0) begin
            bad++;
            $display("FAIL reset_data: got dr=%h adr=%h be=%b dw=%h required zeros", dr1, madr1, mbe1, mdw1);
        end
        @(posedge clk); #1;
        rst = 1'b0; mem_init = 1'b0;
        last_rd1 = 32'd0;
    endtask

    task automatic test_full_read();
        int lat;
        q1.push_back('{dat: 32'h1234ABCD, err: 1'b0, chk: 1'b1});
        req1(22'h000010, 1'b0, 4'hF, 32'd0, 1'b0, lat);
        last_rd1 = 32'h1234ABCD;
        total++;
        if (lat !== 5) begin bad++; $display("FAIL full_read_lat: got %0d required 5", lat); end
        total++;
        if (rec_adr.size() != 4 || rec_adr[0] !== 21'h8 || rec_adr[3] !== 21'h9) begin
            bad++;
            $display("FAIL full_read_mem: got %0d cycles required 4 at adr 8,8,9,9", rec_adr.size());
        end
    endtask

    task automatic test_lo_write();
        int lat;
        q1.push_back('{dat: last_rd1, err: 1'b0, chk: 1'b1});
        req1(22'h000020, 1'b1, 4'b0011, 32'hDEADBEEF, 1'b0, lat);
        total++;
        if (lat !== 3) begin bad++; $display("FAIL lo_write_lat: got %0d required 3", lat); end
        total++;
        if (rec_adr.size() != 2) begin
            bad++; $display("FAIL lo_write_cycles: got %0d required 2", rec_adr.size());
        end
        foreach (rec_adr[i]) begin
            total++;
            if (rec_adr[i] !== 21'h11 || rec_be[i] !== 2'b11 || rec_dw[i] !== 16'hBEEF || rec_we[i] !== 1'b1) begin
                bad++;
                $display("FAIL lo_write_bus: got adr=%h be=%b dw=%h we=%b required 11/11/beef/1",
                         rec_adr[i], rec_be[i], rec_dw[i], rec_we[i]);
            end
        end
        total++;
        if (mem1[8'h11] !== 16'hBEEF || mem1[8'h10] !== 16'h0000) begin
            bad++;
            $display("FAIL lo_write_mem: got %h/%h required beef/0000", mem1[8'h11], mem1[8'h10]);
        end
    endtask

    task automatic test_hi_only();
        int lat;
        q1.push_back('{dat: 32'h12340000, err: 1'b0, chk: 1'b1});
        req1(22'h000010, 1'b0, 4'b1100, 32'd0, 1'b0, lat);
        last_rd1 = 32'h12340000;
        total++;
        if (lat !== 3 || rec_adr.size() != 2 || rec_adr[0] !== 21'h8 || rec_be[0] !== 2'b11) begin
            bad++;
            $display("FAIL hi_only: got lat=%0d cycles=%0d required 3/2", lat, rec_adr.size());
        end
    endtask

    task automatic test_sel_zero();
        int lat;
        q1.push_back('{dat: 32'd0, err: 1'b1, chk: 1'b0});
        req1(22'h000010, 1'b0, 4'h0, 32'd0, 1'b0, lat);
        total++;
        if (lat !== 1 || rec_adr.size() != 0) begin
            bad++;
            $display("FAIL sel_zero: got lat=%0d cycles=%0d required 1/0", lat, rec_adr.size());
        end
    endtask

    task automatic test_mid_change();
        int lat;
        q1.push_back('{dat: 32'h1234ABCD, err: 1'b0, chk: 1'b1});
        req1(22'h000010, 1'b0, 4'hF, 32'h0, 1'b1, lat);
        last_rd1 = 32'h1234ABCD;
        total++;
        if (lat !== 5 || rec_adr.size() != 4) begin
            bad++;
            $display("FAIL mid_change_len: got lat=%0d cycles=%0d required 5/4", lat, rec_adr.size());
        end
        foreach (rec_adr[i]) begin
            total++;
            if (rec_adr[i] !== ((i < 2) ? 21'h8 : 21'h9) || rec_we[i] !== 1'b0 || rec_be[i] !== 2'b11) begin
                bad++;
                $display("FAIL mid_change_bus: got adr=%h we=%b be=%b in cycle %0d", rec_adr[i], rec_we[i], rec_be[i], i);
            end
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic test_back_to_back();
        int ack_cyc[2];
        int k = 0;
        q0.push_back('{dat: 32'h1234ABCD, err: 1'b0, chk: 1'b1});
        q0.push_back('{dat: 32'h56789ABC, err: 1'b0, chk: 1'b1});
        @(posedge clk); #1;
        qs_adr = 22'h000010; qs_we = 1'b0; qs_sel = 4'hF; cs0 = 1'b1;
        for (int n = 0; n < 30 && k < 2; n++) begin
            @(negedge clk);
            if (ack0) begin ack_cyc[k] = n; k++; end
            @(posedge clk);
            if (k == 1 && qs_adr == 22'h000010) begin #1; qs_adr = 22'h000014; end
        end
        #1;
        cs0 = 1'b0;
        total++;
        if (k != 2 || ack_cyc[0] != 3 || ack_cyc[1] != 7) begin
            bad++;
            $display("FAIL b2b_acks: got %0d acks at %0d,%0d required 2 at 3,7", k, ack_cyc[0], ack_cyc[1]);
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset_abort();
        int lat;
        @(posedge clk); #1;
        qs_adr = 22'h000030; qs_we = 1'b1; qs_sel = 4'hF; qs_dat_w = 32'h11223344; cs1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1; cs1 = 1'b0;
        @(negedge clk);
        total++;
        if (mcs1 !== 1'b1) begin bad++; $display("FAIL abort_pre: got mem_cs=%b required 1", mcs1); end
        @(negedge clk);
        total++;
        if ({mcs1, ack1, busy1} !== 3'b000 || dr1 !== 32'd0) begin
            bad++;
            $display("FAIL abort_state: got cs/ack/busy=%b dr=%h required 000/0", {mcs1, ack1, busy1}, dr1);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (mem1[8'h18] !== 16'h1122 || mem1[8'h19] !== 16'h0000) begin
            bad++;
            $display("FAIL abort_mem: got %h/%h required 1122/0000", mem1[8'h18], mem1[8'h19]);
        end
        q1.push_back('{dat: 32'h1234ABCD, err: 1'b0, chk: 1'b1});
        req1(22'h000010, 1'b0, 4'hF, 32'd0, 1'b0, lat);
        total++;
        if (lat !== 5) begin bad++; $display("FAIL abort_next_lat: got %0d required 5", lat); end
        q1.push_back('{dat: 32'h11220000, err: 1'b0, chk: 1'b1});
        req1(22'h000030, 1'b0, 4'hF, 32'd0, 1'b0, lat);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_full_read();
        test_lo_write();
        test_hi_only();
        test_sel_zero();
        test_mid_change();
        test_back_to_back();
        test_reset_abort();
        total++;
        if (q1.size() != 0 || q0.size() != 0) begin
            bad++;
            $display("FAIL missing_acks: got %0d/%0d pending required 0/0", q1.size(), q0.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/qmem_ram_bridge.md
QMEM_RAM_BRIDGE -- requirements
Module: qmem_ram_bridge

Interface
REQ-001 SHALL have parameter QAW, default 22, QMEM byte address width.
REQ-002 SHALL have parameter WS, default 1, wait cycles added to each memory phase (legal 0..15).
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports qs_cs/qs_we  input  1/1  QMEM slave request and write enable, held by master until ack.
REQ-006 SHALL have ports qs_adr  input  QAW  byte address; qs_sel  input  4  byte selects; qs_dat_w  input  32  write data.
REQ-007 SHALL have ports qs_dat_r  output  32  read data; qs_ack  output  1  completion; qs_err  output  1  error, valid with ack.
REQ-008 SHALL have ports mem_adr  output  QAW-1  halfword address; mem_cs  output  1; mem_we  output  1; mem_be  output  2; mem_dat_w  output  16.
REQ-009 SHALL have ports mem_dat_r  input  16  memory read data; busy  output  1  high whenever state is not IDLE.

Function
REQ-010 SHALL be big-endian: qs_sel[3]/qs_dat_w[31:24] is byte adr+0; high halfword (dat[31:16], sel[3:2]) at mem_adr {adr[QAW-1:2],0}; low halfword (dat[15:0], sel[1:0]) at {adr[QAW-1:2],1}.
REQ-011 SHALL implement states IDLE, HI, LO, ACK.
REQ-012 IDLE with qs_cs=1 SHALL latch adr, we, sel, dat_w in that cycle; later changes on qs_* before ack are ignored.
REQ-013 From IDLE on request: sel[3:2]!=0 -> HI; else sel[1:0]!=0 -> LO; sel==0 -> ACK with err=1, no memory access.
REQ-014 HI and LO SHALL each last exactly WS+1 cycles, counted by a 4-bit wait counter reloaded on phase entry.
REQ-015 HI end -> LO if latched sel[1:0]!=0, else ACK; LO end -> ACK.
REQ-016 During HI/LO: mem_cs=1, mem_we=latched we, mem_adr/mem_be/mem_dat_w for that half held constant for the whole phase; outside HI/LO mem_cs=0, mem_we=0, mem_be=0.
REQ-017 Reads SHALL capture mem_dat_r at the clock edge ending the phase's last cycle into the matching qs_dat_r half; a skipped half reads 0.
REQ-018 ACK SHALL last exactly one cycle with qs_ack=1; qs_dat_r valid and stable in that cycle; qs_err=1 only for sel==0; ACK -> IDLE unconditionally.
REQ-019 A new request present in the cycle after ACK SHALL be accepted in that cycle (back-to-back, one IDLE cycle between acks).
REQ-020 Full-word latency: request accepted at cycle 0 -> ack at cycle 2*(WS+1)+1; single-half access -> ack at cycle (WS+1)+1.
REQ-021 Writes SHALL return qs_dat_r unchanged from previous value; qs_err=0.
REQ-022 qs_ack SHALL never assert without a prior accepted request, and never twice per request.

Reset
REQ-023 rst=1 SHALL, at the next edge, force IDLE, wait counter 0, qs_ack=0, qs_err=0, qs_dat_r=0, mem_cs=0, mem_we=0, mem_be=0, mem_adr=0, mem_dat_w=0, busy=0.
REQ-024 rst during HI/LO/ACK SHALL abort the access with no ack; first request after rst deassertion is accepted normally.

Verification
REQ-025 WS=1, read adr 0x000010 sel 4'hF, memory returns 0x1234 at halfword 0x8 and 0xABCD at 0x9 -> mem_cs high cycles 1-4, qs_ack at cycle 5, qs_dat_r=0x1234ABCD.
REQ-026 WS=1, write adr 0x000020 sel 4'b0011 dat 0xDEADBEEF -> only LO phase, mem_adr=0x11, mem_be=2'b11, mem_dat_w=0xBEEF for 2 cycles, ack at cycle 3.
REQ-027 Request with sel=0 -> no mem_cs, qs_ack and qs_err=1 at cycle 1.
REQ-028 WS=0, two back-to-back full-word reads -> each phase one cycle, acks at cycles 3 and 7, data of each read correct.
REQ-029 rst asserted in second HI cycle of a write -> mem_cs=0 next cycle, no ack; subsequent read completes with correct data.
REQ-030 Master changes qs_adr/qs_dat_w mid-access -> memory side shows only latched values; single ack.
